// File: rtl/hex_marquee_pkg.sv
// Shared types and constants for the scrolling 7-segment marquee.
// Segment codes are active-low: bit 0 = top, clockwise, bit 6 = middle.
package hex_marquee_pkg;

  typedef enum logic [2:0] {
    C_H     = 3'd0,
    C_E     = 3'd1,
    C_L     = 3'd2,
    C_P     = 3'd3,
    C_BLANK = 3'd4
  } char_t;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int MAX_MSG_LEN = 16;

  // Only the first MSG_LEN entries are used by a given instance.
  localparam char_t DEFAULT_MSG [MAX_MSG_LEN] = '{
    C_H,     C_E,     C_L,     C_P,
    C_BLANK, C_BLANK, C_BLANK, C_BLANK,
    C_BLANK, C_BLANK, C_BLANK, C_BLANK,
    C_BLANK, C_BLANK, C_BLANK, C_BLANK
  };

endpackage

// File: rtl/hex_marquee_char7seg.sv
// Combinational character-code to active-low 7-segment decoder.
// Reserved codes light nothing.
module char7seg
  import hex_marquee_pkg::*;
(
  input  char_t      ch,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (ch)
      C_H:     seg = SEG_H;
      C_E:     seg = SEG_E;
      C_L:     seg = SEG_L;
      C_P:     seg = SEG_P;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_marquee.sv
// Self-timed scrolling marquee: prescaler, offset ring, wrap-pause FSM
// and a registered multi-digit frame.
//
// state | meaning
// RUN   | advance events move the offset; wrap to 0 may enter HOLD
// HOLD  | offset frozen on 0 for PAUSE_TICKS ticks; a step aborts
module hex_marquee
  import hex_marquee_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int MSG_LEN     = 8,
  parameter int TICK_DIV    = 50000000,
  parameter int PAUSE_TICKS = 2,
  localparam int OFS_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    dir,
  input  logic                    step,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic [OFS_W-1:0]        offset
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (PAUSE_TICKS > 0) ? $clog2(PAUSE_TICKS + 1) : 1;

  logic [PW-1:0]          presc;
  logic                   tick;
  logic                   adv;
  state_t                 state, state_nxt;
  logic [CW-1:0]          pause_cnt, pause_nxt;
  logic [OFS_W-1:0]       offset_nxt;
  logic [OFS_W-1:0]       off_step;
  logic [7*NUM_DIGITS-1:0] frame;

  assign tick = en && (presc == PW'(TICK_DIV - 1));
  // A step coinciding with a tick still produces a single advance.
  assign adv  = tick | step;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (en) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  always_comb begin
    off_step = offset;
    if (dir) begin
      off_step = (offset == '0) ? OFS_W'(MSG_LEN - 1) : offset - 1'b1;
    end else begin
      off_step = (offset == OFS_W'(MSG_LEN - 1)) ? '0 : offset + 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    offset_nxt = offset;
    pause_nxt  = pause_cnt;
    case (state)
      RUN: begin
        if (adv) begin
          offset_nxt = off_step;
          if ((off_step == '0) && (PAUSE_TICKS > 0)) begin
            state_nxt = HOLD;
            pause_nxt = CW'(PAUSE_TICKS);
          end
        end
      end
      HOLD: begin
        if (step) begin
          offset_nxt = off_step;
          pause_nxt  = '0;
          state_nxt  = RUN;
        end else if (tick) begin
          pause_nxt = pause_cnt - 1'b1;
          if (pause_cnt == CW'(1)) begin
            state_nxt = RUN;
          end
        end
      end
      default: begin
        state_nxt = RUN;
        pause_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      offset    <= '0;
      pause_cnt <= '0;
    end else begin
      state     <= state_nxt;
      offset    <= offset_nxt;
      pause_cnt <= pause_nxt;
    end
  end

  // Digit k shows message[(offset + NUM_DIGITS-1-k) mod MSG_LEN]; the sum is
  // below 2*MSG_LEN so one conditional subtract replaces the modulo.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    localparam int SHIFT = NUM_DIGITS - 1 - k;
    logic [4:0] sum;
    logic [3:0] idx;
    char_t      ch;
    logic [6:0] seg;

    assign sum = 5'(offset) + 5'(SHIFT);
    assign idx = (sum >= 5'(MSG_LEN)) ? 4'(sum - 5'(MSG_LEN)) : sum[3:0];
    assign ch  = DEFAULT_MSG[idx];

    char7seg u_char7seg (
      .ch  (ch),
      .seg (seg)
    );

    assign frame[7*k +: 7] = seg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hex <= '1;
    end else begin
      hex <= frame;
    end
  end

endmodule
